// File: rtl/l1i_fetch_arbiter_if.sv
// Bundle of the arbiter's request, L1I and response signals.
// slave is the arbiter's view; master is the view of the requesters, the L1I and the status consumers.
interface l1i_fetch_arbiter_if #(
    parameter int unsigned ADDR_WIDTH   = 64,
    parameter int unsigned LINE_BYTES   = 64,
    parameter int unsigned MAX_INFLIGHT = 4
);
    localparam int unsigned CntW = $clog2(MAX_INFLIGHT) + 1;

    logic                    flush_in;
    logic                    bp_req_valid;
    logic [ADDR_WIDTH-1:0]   bp_req_addr;
    logic                    bp_req_ready;
    logic                    pf_req_valid;
    logic [ADDR_WIDTH-1:0]   pf_req_addr;
    logic                    pf_req_ready;
    logic                    l1i_req_valid;
    logic [ADDR_WIDTH-1:0]   l1i_req_addr;
    logic                    l1i_req_ready;
    logic                    l1i_resp_valid;
    logic [LINE_BYTES*8-1:0] l1i_resp_line;
    logic                    bp_resp_valid;
    logic                    pf_resp_valid;
    logic [ADDR_WIDTH-1:0]   resp_addr;
    logic [LINE_BYTES*8-1:0] resp_line;
    logic [CntW-1:0]         inflight_cnt;
    logic                    err_unexp_resp;

    modport slave (
        input  flush_in, bp_req_valid, bp_req_addr, pf_req_valid, pf_req_addr,
               l1i_req_ready, l1i_resp_valid, l1i_resp_line,
        output bp_req_ready, pf_req_ready, l1i_req_valid, l1i_req_addr,
               bp_resp_valid, pf_resp_valid, resp_addr, resp_line, inflight_cnt, err_unexp_resp
    );

    modport master (
        output flush_in, bp_req_valid, bp_req_addr, pf_req_valid, pf_req_addr,
               l1i_req_ready, l1i_resp_valid, l1i_resp_line,
        input  bp_req_ready, pf_req_ready, l1i_req_valid, l1i_req_addr,
               bp_resp_valid, pf_resp_valid, resp_addr, resp_line, inflight_cnt, err_unexp_resp
    );
endinterface

// File: rtl/l1i_fetch_arbiter.sv
// Shares the L1I port between demand fetch and next-line prefetch, tracks in-order misses.
// Prefetch requester is compiled in only when L1I_ARB_PF_EN is defined.
module l1i_fetch_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 64,
    parameter int unsigned LINE_BYTES   = 64,
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input logic                clk_in,
    input logic                rst_in,
    l1i_fetch_arbiter_if.slave bus
);
    localparam int unsigned PtrW = $clog2(MAX_INFLIGHT);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned LineW = LINE_BYTES * 8;
    localparam logic [ADDR_WIDTH-1:0] LineMask = ~ADDR_WIDTH'(LINE_BYTES - 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_INFLIGHT);

    typedef enum logic [0:0] {StEmpty, StHold} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] hold_addr_q, hold_addr_d;
    logic                  hold_sq_q, hold_sq_d;

    logic [ADDR_WIDTH-1:0] trk_addr_q [MAX_INFLIGHT];
    logic [MAX_INFLIGHT-1:0] trk_sq_q;
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]       occ_q;

    logic                  bp_resp_q;
    logic [ADDR_WIDTH-1:0] resp_addr_q;
    logic [LineW-1:0]      resp_line_q;
    logic                  err_q;

    logic                  hold, issue, pop, stray, deliver, can_acc, bp_acc, pf_acc, pf_ready;
    logic                  src_is_pf;
    logic [CntW-1:0]       inflight;
    logic [ADDR_WIDTH-1:0] bp_line;

`ifdef L1I_ARB_PF_EN
    logic                  hold_src_q, hold_src_d;
    logic [MAX_INFLIGHT-1:0] trk_src_q;
    logic                  pf_resp_q;
    logic [ADDR_WIDTH-1:0] pf_line;

    assign pf_line   = bus.pf_req_addr & LineMask;
    // A prefetch of the line demand is already fetching is acked and discarded.
    assign pf_ready  = can_acc & (!bus.bp_req_valid | (bp_line == pf_line));
    assign pf_acc    = bus.pf_req_valid & can_acc & !bus.bp_req_valid;
    assign src_is_pf = trk_src_q[rd_ptr_q];
`else
    logic pf_unused;

    assign pf_unused = ^{bus.pf_req_valid, bus.pf_req_addr};
    assign pf_ready  = 1'b0;
    assign pf_acc    = 1'b0;
    assign src_is_pf = 1'b0;
`endif

    assign hold     = (state_q == StHold);
    assign issue    = hold & bus.l1i_req_ready;
    assign pop      = bus.l1i_resp_valid & (occ_q != '0);
    assign stray    = bus.l1i_resp_valid & (occ_q == '0);
    assign deliver  = pop & !trk_sq_q[rd_ptr_q] & !bus.flush_in;
    assign inflight = CntW'(hold) + occ_q;
    assign bp_line  = bus.bp_req_addr & LineMask;
    // A same-cycle return frees a slot, so a full arbiter can still accept.
    assign can_acc  = !rst_in & !bus.flush_in & (!hold | bus.l1i_req_ready)
                      & ((inflight < MaxCnt) | bus.l1i_resp_valid);
    assign bp_acc   = bus.bp_req_valid & can_acc;

    always_comb begin
        state_d     = state_q;
        hold_addr_d = hold_addr_q;
        hold_sq_d   = hold_sq_q | bus.flush_in;
`ifdef L1I_ARB_PF_EN
        hold_src_d  = hold_src_q;
`endif
        if (bp_acc) begin
            state_d     = StHold;
            hold_addr_d = bp_line;
            hold_sq_d   = 1'b0;
`ifdef L1I_ARB_PF_EN
            hold_src_d  = 1'b0;
        end else if (pf_acc) begin
            state_d     = StHold;
            hold_addr_d = pf_line;
            hold_sq_d   = 1'b0;
            hold_src_d  = 1'b1;
`endif
        end else if (issue) begin
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= StEmpty;
            hold_addr_q <= '0;
            hold_sq_q   <= 1'b0;
`ifdef L1I_ARB_PF_EN
            hold_src_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            hold_addr_q <= hold_addr_d;
            hold_sq_q   <= hold_sq_d;
`ifdef L1I_ARB_PF_EN
            hold_src_q  <= hold_src_d;
`endif
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < MAX_INFLIGHT; i++) begin
                trk_addr_q[i] <= '0;
            end
            trk_sq_q <= '0;
`ifdef L1I_ARB_PF_EN
            trk_src_q <= '0;
`endif
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (bus.flush_in) begin
                trk_sq_q <= '1;
            end
            if (issue) begin
                trk_addr_q[wr_ptr_q] <= hold_addr_q;
                trk_sq_q[wr_ptr_q]   <= hold_sq_q | bus.flush_in;
`ifdef L1I_ARB_PF_EN
                trk_src_q[wr_ptr_q]  <= hold_src_q;
`endif
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            occ_q <= occ_q + CntW'(issue) - CntW'(pop);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            bp_resp_q   <= 1'b0;
`ifdef L1I_ARB_PF_EN
            pf_resp_q   <= 1'b0;
`endif
            resp_addr_q <= '0;
            resp_line_q <= '0;
            err_q       <= 1'b0;
        end else begin
            bp_resp_q <= deliver & !src_is_pf;
`ifdef L1I_ARB_PF_EN
            pf_resp_q <= deliver & src_is_pf;
`endif
            if (deliver) begin
                resp_addr_q <= trk_addr_q[rd_ptr_q];
                resp_line_q <= bus.l1i_resp_line;
            end
            err_q <= err_q | stray;
        end
    end

    assign bus.bp_req_ready   = can_acc;
    assign bus.pf_req_ready   = pf_ready;
    assign bus.l1i_req_valid  = hold;
    assign bus.l1i_req_addr   = hold_addr_q;
    assign bus.bp_resp_valid  = bp_resp_q;
`ifdef L1I_ARB_PF_EN
    assign bus.pf_resp_valid  = pf_resp_q;
`else
    assign bus.pf_resp_valid  = 1'b0;
`endif
    assign bus.resp_addr      = resp_addr_q;
    assign bus.resp_line      = resp_line_q;
    assign bus.inflight_cnt   = inflight;
    assign bus.err_unexp_resp = err_q;
endmodule

// File: tb/tb_l1i_fetch_arbiter.sv
// Self-checking bench for l1i_fetch_arbiter: directed scenarios plus random traffic against a
// queue-based reference model.
module tb_l1i_fetch_arbiter;
    localparam int unsigned AW = 64;
    localparam int unsigned LB = 64;
    localparam int unsigned MI = 4;
    localparam int unsigned LW = LB * 8;
`ifdef L1I_ARB_PF_EN
    localparam bit PfEn = 1'b1;
`else
    localparam bit PfEn = 1'b0;
`endif

    typedef struct {
        logic [AW-1:0] addr;
        bit            src;
        bit            sq;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    l1i_fetch_arbiter_if #(.ADDR_WIDTH(AW), .LINE_BYTES(LB), .MAX_INFLIGHT(MI)) bus ();

    l1i_fetch_arbiter #(.ADDR_WIDTH(AW), .LINE_BYTES(LB), .MAX_INFLIGHT(MI)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    int n_err = 0;
    int n_chk = 0;

    ent_t          trk[$];
    bit            m_hold, m_src, m_sq;
    logic [AW-1:0] m_addr;
    bit            exp_bp, exp_pf, exp_err;
    logic [AW-1:0] exp_addr;
    logic [LW-1:0] exp_line;

    task automatic check_eq(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] line_of(input logic [AW-1:0] a);
        return (a / LB) * LB;
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return {$urandom, $urandom};
        return AW'(32'h1000 + $urandom_range(0, 7) * 64 + $urandom_range(0, 63));
    endfunction

    task automatic model_reset();
        trk.delete();
        m_hold = 0; m_src = 0; m_sq = 0; m_addr = '0;
        exp_bp = 0; exp_pf = 0; exp_err = 0; exp_addr = '0; exp_line = '0;
    endtask

    task automatic drive_idle();
        bus.flush_in = 0; bus.bp_req_valid = 0; bus.bp_req_addr = '0;
        bus.pf_req_valid = 0; bus.pf_req_addr = '0; bus.l1i_req_ready = 0;
        bus.l1i_resp_valid = 0; bus.l1i_resp_line = '0;
    endtask

    // Asserted away from the clock edge so the checks observe the asynchronous clear.
    task automatic reset_dut();
        drive_idle();
        rst = 1'b1;
        #1;
        check_eq("rst_bp_req_ready", bus.bp_req_ready, 0);
        check_eq("rst_pf_req_ready", bus.pf_req_ready, 0);
        check_eq("rst_l1i_req_valid", bus.l1i_req_valid, 0);
        check_eq("rst_l1i_req_addr", bus.l1i_req_addr, 0);
        check_eq("rst_bp_resp_valid", bus.bp_resp_valid, 0);
        check_eq("rst_pf_resp_valid", bus.pf_resp_valid, 0);
        check_eq("rst_resp_addr", bus.resp_addr, 0);
        check_eq("rst_resp_line", bus.resp_line, 0);
        check_eq("rst_inflight_cnt", bus.inflight_cnt, 0);
        check_eq("rst_err", bus.err_unexp_resp, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One clock: apply inputs, check combinational outputs, advance model, check registered ones.
    task automatic cycle(input bit bpv, input logic [AW-1:0] bpa, input bit pfv,
                         input logic [AW-1:0] pfa, input bit rdy, input bit rv, input bit fl);
        int            cnt;
        bit            can, pfr, nb, np;
        logic [LW-1:0] ln;
        ent_t          e;
        ln = rand_line();
        bus.bp_req_valid = bpv; bus.bp_req_addr = bpa;
        bus.pf_req_valid = pfv; bus.pf_req_addr = pfa;
        bus.l1i_req_ready = rdy; bus.l1i_resp_valid = rv; bus.l1i_resp_line = ln;
        bus.flush_in = fl;
        #1;
        cnt = int'(m_hold) + trk.size();
        can = !fl && (!m_hold || rdy) && (cnt < MI || rv);
        pfr = PfEn && can && (!bpv || line_of(bpa) == line_of(pfa));
        check_eq("bp_req_ready", bus.bp_req_ready, can);
        check_eq("pf_req_ready", bus.pf_req_ready, pfr);
        check_eq("l1i_req_valid", bus.l1i_req_valid, m_hold);
        if (m_hold) check_eq("l1i_req_addr", bus.l1i_req_addr, m_addr);
        check_eq("inflight_cnt", bus.inflight_cnt, cnt);

        nb = 0; np = 0;
        if (rv) begin
            if (trk.size() > 0) begin
                e = trk.pop_front();
                if (!e.sq && !fl) begin
                    nb = !e.src; np = e.src; exp_addr = e.addr; exp_line = ln;
                end
            end else begin
                exp_err = 1'b1;
            end
        end
        if (m_hold && rdy) trk.push_back('{m_addr, m_src, m_sq || fl});
        if (fl) begin
            for (int i = 0; i < trk.size(); i++) begin
                e = trk[i]; e.sq = 1'b1; trk[i] = e;
            end
            m_sq = 1'b1;
        end
        if (bpv && can) begin
            m_hold = 1; m_addr = line_of(bpa); m_src = 0; m_sq = 0;
        end else if (pfv && pfr && !bpv) begin
            m_hold = 1; m_addr = line_of(pfa); m_src = 1; m_sq = 0;
        end else if (m_hold && rdy) begin
            m_hold = 0;
        end
        exp_bp = nb; exp_pf = np;

        @(posedge clk);
        #1;
        check_eq("bp_resp_valid", bus.bp_resp_valid, exp_bp);
        check_eq("pf_resp_valid", bus.pf_resp_valid, exp_pf);
        check_eq("err_unexp_resp", bus.err_unexp_resp, exp_err);
        if (exp_bp || exp_pf) begin
            check_eq("resp_addr", bus.resp_addr, exp_addr);
            check_eq("resp_line", bus.resp_line, exp_line);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (m_hold || trk.size() > 0); i++) begin
            cycle(0, '0, 0, '0, 1, trk.size() > 0, 0);
        end
        check_eq("drain_inflight", bus.inflight_cnt, 0);
    endtask

    int unsigned ph_bp[4]    = '{60, 90, 30, 70};
    int unsigned ph_pf[4]    = '{60, 50, 80, 70};
    int unsigned ph_rdy[4]   = '{80, 30, 90, 100};
    int unsigned ph_resp[4]  = '{50, 10, 80, 100};
    int unsigned ph_flush[4] = '{3, 2, 5, 0};

    initial begin
        drive_idle();
        #2;
        reset_dut();

        // Demand only: accept, issue one cycle later, response routed one cycle after return.
        cycle(1, 64'h1234, 0, '0, 1, 0, 0);
        check_eq("dir_req_valid", bus.l1i_req_valid, 1);
        check_eq("dir_req_addr", bus.l1i_req_addr, 64'h1200);
        cycle(0, '0, 0, '0, 1, 0, 0);
        cycle(0, '0, 0, '0, 0, 0, 0);
        cycle(0, '0, 0, '0, 0, 0, 0);
        cycle(0, '0, 0, '0, 0, 1, 0);
        check_eq("dir_bp_resp", bus.bp_resp_valid, 1);
        check_eq("dir_resp_addr", bus.resp_addr, 64'h1200);

        // Fill to the limit, then accept against a same-cycle return.
        for (int i = 0; i < 5; i++) cycle(1, 64'h10000 + 64'(i * 64), 0, '0, 1, 0, 0);
        check_eq("full_inflight", bus.inflight_cnt, 4);
        check_eq("full_bp_ready", bus.bp_req_ready, 0);
        cycle(1, 64'h20000, 0, '0, 1, 1, 0);
        check_eq("full_swap_inflight", bus.inflight_cnt, 4);
        drain();

        // Flush with three issued and one held: none of their responses may surface.
        for (int i = 0; i < 4; i++) cycle(1, 64'h30000 + 64'(i * 64), 0, '0, 1, 0, 0);
        cycle(1, 64'h38000, 0, '0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            cycle(0, '0, 0, '0, 1, 1, 0);
            check_eq("flush_no_resp", bus.bp_resp_valid, 0);
        end
        cycle(1, 64'h9000, 0, '0, 1, 0, 0);
        cycle(0, '0, 0, '0, 1, 0, 0);
        cycle(0, '0, 0, '0, 0, 1, 0);
        check_eq("post_flush_resp", bus.bp_resp_valid, 1);
        check_eq("post_flush_addr", bus.resp_addr, 64'h9000);

`ifdef L1I_ARB_PF_EN
        cycle(1, 64'h2040, 1, 64'h2040, 1, 0, 0);
        check_eq("dedup_addr", bus.l1i_req_addr, 64'h2040);
        cycle(0, '0, 0, '0, 1, 0, 0);
        check_eq("dedup_single", bus.l1i_req_valid, 0);
        drain();
        cycle(1, 64'h4000, 1, 64'h8000, 1, 0, 0);
        cycle(0, '0, 1, 64'h8000, 1, 0, 0);
        cycle(0, '0, 0, '0, 1, 0, 0);
        cycle(0, '0, 0, '0, 0, 1, 0);
        check_eq("cont_bp_resp", bus.bp_resp_valid, 1);
        check_eq("cont_bp_addr", bus.resp_addr, 64'h4000);
        cycle(0, '0, 0, '0, 0, 1, 0);
        check_eq("cont_pf_resp", bus.pf_resp_valid, 1);
        check_eq("cont_pf_addr", bus.resp_addr, 64'h8000);
`else
        for (int i = 0; i < 10; i++) begin
            cycle(0, '0, 1, 64'h100, 1, 0, 0);
            check_eq("pf_off_ready", bus.pf_req_ready, 0);
            check_eq("pf_off_no_req", bus.l1i_req_valid, 0);
        end
`endif

        for (int p = 0; p < 4; p++) begin
            for (int n = 0; n < 350; n++) begin
                cycle($urandom_range(0, 99) < ph_bp[p], rand_addr(),
                      $urandom_range(0, 99) < ph_pf[p], rand_addr(),
                      $urandom_range(0, 99) < ph_rdy[p],
                      (trk.size() > 0) && ($urandom_range(0, 99) < ph_resp[p]),
                      $urandom_range(0, 99) < ph_flush[p]);
            end
        end
        drain();

        // Stray response sets the sticky error.
        cycle(0, '0, 0, '0, 0, 1, 0);
        check_eq("stray_err", bus.err_unexp_resp, 1);
        cycle(0, '0, 0, '0, 0, 0, 0);
        check_eq("stray_err_sticky", bus.err_unexp_resp, 1);

        // Reset mid-transaction abandons the tracker; its late response is then unexpected.
        cycle(1, 64'h5000, 0, '0, 1, 0, 0);
        cycle(0, '0, 0, '0, 1, 0, 0);
        reset_dut();
        cycle(0, '0, 0, '0, 0, 1, 0);
        check_eq("post_rst_stray_err", bus.err_unexp_resp, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
